// File: rtl/sv_packet_rx_if.sv
// Valid/ready output bus of the packet receiver.
// master = receiver (drives head packet), slave = downstream sink.
interface sv_packet_rx_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic [3:0] dest_out;

    modport master (output out_valid, output data_out, output dest_out, input out_ready);
    modport slave  (input out_valid, input data_out, input dest_out, output out_ready);
endinterface

// File: rtl/sv_packet_rx.sv
// Packet link receiver: parity check, destination filter, small FIFO, valid/ready output.
// Optional macro PKT_STATS_EN adds acc_cnt/drop_cnt statistics outputs.
module sv_packet_rx #(
    parameter logic [3:0] MY_ADDR  = 4'h3,
    parameter bit         BCAST_EN = 1'b1,
    parameter int         DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [13:0]           packet_in,
    input  logic                  clr_err,
    sv_packet_rx_if.master        rx_out,
    output logic                  overflow,
    output logic [7:0]            par_err_cnt
`ifdef PKT_STATS_EN
    ,
    output logic [15:0]           acc_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][11:0] mem;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;

    logic pkt_vld, par_ok, dest_hit, accept, full, pop, push, ovf_set, par_fail;

    // Even parity over [12:0] means the XOR of those bits is zero.
    assign pkt_vld  = packet_in[13];
    assign par_ok   = ~(^packet_in[12:0]);
    assign par_fail = pkt_vld && !par_ok;
    assign dest_hit = (packet_in[11:8] == MY_ADDR) ||
                      (BCAST_EN && (packet_in[11:8] == 4'hF));
    assign accept   = pkt_vld && par_ok && dest_hit;

    assign full    = (count == FULL_CNT);
    assign pop     = rx_out.out_valid && rx_out.out_ready;
    // A same-cycle pop frees the slot, so a push on full is still taken.
    assign push    = accept && (!full || pop);
    assign ovf_set = accept && full && !pop;

    assign rx_out.out_valid = (count != '0);
    assign rx_out.data_out  = mem[rd_ptr][7:0];
    assign rx_out.dest_out  = mem[rd_ptr][11:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= packet_in[11:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // clr_err has priority over a same-cycle set/increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            par_err_cnt <= '0;
        end else if (clr_err) begin
            overflow    <= 1'b0;
            par_err_cnt <= '0;
        end else begin
            if (ovf_set)
                overflow <= 1'b1;
            if (par_fail && (par_err_cnt != 8'hFF))
                par_err_cnt <= par_err_cnt + 1'b1;
        end
    end

`ifdef PKT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept)
                acc_cnt <= acc_cnt + 1'b1;
            if (pkt_vld && par_ok && !dest_hit)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sv_packet_rx.sv
// Scoreboard bench for sv_packet_rx (MY_ADDR=3, BCAST_EN=1, DEPTH=4).
module tb_sv_packet_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] packet_in;
    logic        clr_err;
    logic        overflow;
    logic [7:0]  par_err_cnt;
`ifdef PKT_STATS_EN
    logic [15:0] acc_cnt, drop_cnt;
`endif

    sv_packet_rx_if bus ();

    sv_packet_rx #(.MY_ADDR(4'h3), .BCAST_EN(1'b1), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .packet_in   (packet_in),
        .clr_err     (clr_err),
        .rx_out      (bus.master),
        .overflow    (overflow),
        .par_err_cnt (par_err_cnt)
`ifdef PKT_STATS_EN
        ,
        .acc_cnt     (acc_cnt),
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid && ready here.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got %h expected none", {bus.dest_out, bus.data_out});
            end else begin
                chk("pop_pkt", {4'h0, bus.dest_out, bus.data_out}, {4'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one link word for a cycle; when expected accepted, queue its payload.
    task automatic send(input logic [13:0] pkt, input bit exp_acc);
        packet_in = pkt;
        if (exp_acc) exp_q.push_back(pkt[11:0]);
        step();
        packet_in = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        packet_in = '0;
        clr_err = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_valid", {15'h0, bus.out_valid}, 16'h0);
        chk("rst_data", {8'h0, bus.data_out}, 16'h0);
        chk("rst_dest", {12'h0, bus.dest_out}, 16'h0);
        chk("rst_ovf", {15'h0, overflow}, 16'h0);
        chk("rst_perr", {8'h0, par_err_cnt}, 16'h0);
        rst_n = 1'b1;
        step();

        // 1: single packet, one-cycle latency, drained next edge
        bus.out_ready = 1'b1;
        send(14'h23A5, 1'b1);
        chk("t1_valid", {15'h0, bus.out_valid}, 16'h1);
        chk("t1_data", {8'h0, bus.data_out}, 16'h00A5);
        chk("t1_dest", {12'h0, bus.dest_out}, 16'h0003);
        step();
        chk("t1_empty", {15'h0, bus.out_valid}, 16'h0);

        // 2: dest mismatch is a silent discard
        send(14'h3755, 1'b0);
        chk("t2_valid", {15'h0, bus.out_valid}, 16'h0);
        chk("t2_perr", {8'h0, par_err_cnt}, 16'h0);
`ifdef PKT_STATS_EN
        chk("t2_drop", drop_cnt, 16'h0001);
`endif

        // 3: parity error count, clear, clear beats increment
        send(14'h33A5, 1'b0);
        chk("t3_valid", {15'h0, bus.out_valid}, 16'h0);
        chk("t3_perr", {8'h0, par_err_cnt}, 16'h0001);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t3_clr", {8'h0, par_err_cnt}, 16'h0);
        send(14'h33A5, 1'b0);
        send(14'h33A5, 1'b0);
        chk("t3_perr2", {8'h0, par_err_cnt}, 16'h0002);
        clr_err = 1'b1;
        send(14'h33A5, 1'b0);
        clr_err = 1'b0;
        chk("t3_clr_pri", {8'h0, par_err_cnt}, 16'h0);

        // 4: fill with ready low; fifth packet overflows
        bus.out_ready = 1'b0;
        send(14'h3301, 1'b1);
        send(14'h3302, 1'b1);
        send(14'h2303, 1'b1);
        send(14'h3304, 1'b1);
        chk("t4_no_ovf", {15'h0, overflow}, 16'h0);
        send(14'h2305, 1'b0);
        chk("t4_ovf", {15'h0, overflow}, 16'h1);
        step();
        chk("t4_hold_data", {8'h0, bus.data_out}, 16'h0001);
        chk("t4_hold_valid", {15'h0, bus.out_valid}, 16'h1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t4_ovf_clr", {15'h0, overflow}, 16'h0);

        // 5: push on full with same-cycle pop is accepted
        bus.out_ready = 1'b1;
        send(14'h2306, 1'b1);
        chk("t5_no_ovf", {15'h0, overflow}, 16'h0);
        repeat (6) step();
        chk("t5_drained", {15'h0, bus.out_valid}, 16'h0);
        chk("t5_q_empty", 16'(exp_q.size()), 16'h0);
        chk("t5_ovf_end", {15'h0, overflow}, 16'h0);
`ifdef PKT_STATS_EN
        chk("t5_acc", acc_cnt, 16'h0007);
`endif

        // 6: broadcast accepted; reset while full clears at once
        bus.out_ready = 1'b0;
        send(14'h2F5A, 1'b1);
        chk("t6_valid", {15'h0, bus.out_valid}, 16'h1);
        chk("t6_dest", {12'h0, bus.dest_out}, 16'h000F);
        chk("t6_data", {8'h0, bus.data_out}, 16'h005A);
        send(14'h3301, 1'b1);
        send(14'h3302, 1'b1);
        send(14'h2303, 1'b1);
        send(14'h3304, 1'b0);
        chk("t6_ovf", {15'h0, overflow}, 16'h1);
`ifdef PKT_STATS_EN
        chk("t6_acc", acc_cnt, 16'h000C);
`endif
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_valid", {15'h0, bus.out_valid}, 16'h0);
        chk("t6_rst_data", {8'h0, bus.data_out}, 16'h0);
        chk("t6_rst_ovf", {15'h0, overflow}, 16'h0);
`ifdef PKT_STATS_EN
        chk("t6_rst_acc", acc_cnt, 16'h0);
        chk("t6_rst_drop", drop_cnt, 16'h0);
`endif
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(14'h2306, 1'b1);
        chk("t6_post_data", {8'h0, bus.data_out}, 16'h0006);
        repeat (3) step();
        chk("end_q_empty", 16'(exp_q.size()), 16'h0);
        chk("end_valid", {15'h0, bus.out_valid}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
